// File: rtl/terminal_write_ctrl.sv
// Write sequencer for the character grid BRAM: takes a byte stream, keeps the cursor,
// and owns every grid write, including the row and full-screen clear sweeps.
//
// state     | meaning
// IDLE      | ready for a byte; printable/control codes handled on acceptance
// CLEAR_ROW | zeroing the row the cursor just entered, one cell per cycle
// CLEAR_ALL | zeroing the whole grid from address 0, one cell per cycle
module terminal_write_ctrl #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int ADDR_W        = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter int X_W           = $clog2(SCREEN_WIDTH),
  parameter int Y_W           = $clog2(SCREEN_HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        char_in,
  input  logic              char_valid_in,
  output logic              char_ready_out,
  output logic              tg_write_en_out,
  output logic [ADDR_W-1:0] tg_addr_out,
  output logic [7:0]        tg_data_out,
  output logic [X_W-1:0]    cursor_x_out,
  output logic [Y_W-1:0]    cursor_y_out,
  output logic              busy_out
);

  localparam logic [X_W-1:0]    X_LAST     = X_W'(SCREEN_WIDTH-1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(SCREEN_HEIGHT-1);
  localparam logic [ADDR_W-1:0] WIDTH_A    = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] ROW_LEN_TC = ADDR_W'(SCREEN_WIDTH-1);
  localparam logic [ADDR_W-1:0] ALL_LEN_TC = ADDR_W'(SCREEN_WIDTH*SCREEN_HEIGHT-1);

  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

  state_t            state, state_nxt;
  logic [X_W-1:0]    cur_x, cur_x_nxt;
  logic [Y_W-1:0]    cur_y, cur_y_nxt;
  logic [ADDR_W-1:0] sweep_addr, sweep_addr_nxt;
  logic [ADDR_W-1:0] sweep_left, sweep_left_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              accept;
  logic [Y_W-1:0]    y_adv;
  logic [ADDR_W-1:0] cur_addr;

  // Product is taken at ADDR_W so the largest row base still fits the grid address.
  function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y);
    return ADDR_W'(y) * WIDTH_A;
  endfunction

  assign char_ready_out = (state == IDLE);
  assign busy_out       = (state != IDLE);
  assign accept         = char_valid_in && char_ready_out;
  assign y_adv          = (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
  assign cur_addr       = row_base(cur_y) + ADDR_W'(cur_x);
  assign cursor_x_out   = cur_x;
  assign cursor_y_out   = cur_y;

  always_comb begin
    state_nxt      = state;
    cur_x_nxt      = cur_x;
    cur_y_nxt      = cur_y;
    sweep_addr_nxt = sweep_addr;
    sweep_left_nxt = sweep_left;
    we_nxt         = 1'b0;
    addr_nxt       = tg_addr_out;
    data_nxt       = tg_data_out;
    case (state)
      IDLE: begin
        if (accept) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            data_nxt = char_in;
            if (cur_x == X_LAST) begin
              cur_x_nxt      = '0;
              cur_y_nxt      = y_adv;
              state_nxt      = CLEAR_ROW;
              sweep_addr_nxt = row_base(y_adv);
              sweep_left_nxt = ROW_LEN_TC;
            end else begin
              cur_x_nxt = cur_x + X_W'(1);
            end
          end else begin
            case (char_in)
              8'h0A: begin
                cur_x_nxt      = '0;
                cur_y_nxt      = y_adv;
                state_nxt      = CLEAR_ROW;
                sweep_addr_nxt = row_base(y_adv);
                sweep_left_nxt = ROW_LEN_TC;
              end
              8'h0D: cur_x_nxt = '0;
              8'h08: begin
                if (cur_x != '0 || cur_y != '0) begin
                  we_nxt   = 1'b1;
                  data_nxt = 8'h00;
                  if (cur_x == '0) begin
                    cur_x_nxt = X_LAST;
                    cur_y_nxt = cur_y - Y_W'(1);
                    addr_nxt  = row_base(cur_y - Y_W'(1)) + ADDR_W'(X_LAST);
                  end else begin
                    cur_x_nxt = cur_x - X_W'(1);
                    addr_nxt  = cur_addr - ADDR_W'(1);
                  end
                end
              end
              8'h0C: begin
                cur_x_nxt      = '0;
                cur_y_nxt      = '0;
                state_nxt      = CLEAR_ALL;
                sweep_addr_nxt = '0;
                sweep_left_nxt = ALL_LEN_TC;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        we_nxt   = 1'b1;
        addr_nxt = sweep_addr;
        data_nxt = 8'h00;
        // sweep_left counts down to terminal count; pointers hold on the last cell
        if (sweep_left == '0) begin
          state_nxt = IDLE;
        end else begin
          sweep_addr_nxt = sweep_addr + ADDR_W'(1);
          sweep_left_nxt = sweep_left - ADDR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= CLEAR_ALL;
      cur_x           <= '0;
      cur_y           <= '0;
      sweep_addr      <= '0;
      sweep_left      <= ALL_LEN_TC;
      tg_write_en_out <= 1'b0;
      tg_addr_out     <= '0;
      tg_data_out     <= 8'h00;
    end else begin
      state           <= state_nxt;
      cur_x           <= cur_x_nxt;
      cur_y           <= cur_y_nxt;
      sweep_addr      <= sweep_addr_nxt;
      sweep_left      <= sweep_left_nxt;
      tg_write_en_out <= we_nxt;
      tg_addr_out     <= addr_nxt;
      tg_data_out     <= data_nxt;
    end
  end

endmodule

// File: tb/tb_terminal_write_ctrl.sv
// Directed bench for terminal_write_ctrl: a table of single-byte transactions plus
// hand sequences for streaming, row wrap, bottom wrap and reset during a sweep.
module tb_terminal_write_ctrl;
  localparam int W  = 76;
  localparam int H  = 44;
  localparam int N  = W*H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    ch = 8'h00;
  logic          valid = 1'b0;
  logic          ready, we, busy;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  terminal_write_ctrl #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk_in(clk), .rst_in(rst_n), .char_in(ch), .char_valid_in(valid),
    .char_ready_out(ready), .tg_write_en_out(we), .tg_addr_out(addr),
    .tg_data_out(data), .cursor_x_out(cx), .cursor_y_out(cy), .busy_out(busy)
  );

  typedef struct {
    logic [7:0] ch;
    logic       we;
    int         addr;
    logic [7:0] data;
    int         x;
    int         y;
    int         sweep;   // 0 none, 1 row, 2 whole screen
    int         base;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard = 0;
    ch = b;
    valid = 1'b1;
    while (!ready && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10000) begin
      n_vec++;
      n_err++;
      $display("FAIL send timeout: ready stayed %0d, required 1", ready);
    end
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_sweep(input string name, input int base, input int len);
    int bad = 0;
    int first_i = -1;
    int g_we = 0, g_a = 0, g_d = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (!(we === 1'b1 && int'(addr) == base + i && data === 8'h00)) begin
        if (bad == 0) begin
          first_i = i; g_we = int'(we); g_a = int'(addr); g_d = int'(data);
        end
        bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d bad writes, first at step %0d got we=%0d addr=%0d data=%0h, required we=1 addr=%0d data=0",
               name, bad, first_i, g_we, g_a, g_d, base + first_i);
    end
    check({name, " ready after"}, int'(ready), 1);
    check({name, " busy after"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " we"},    int'(we), 0);
    check({name, " addr"},  int'(addr), 0);
    check({name, " data"},  int'(data), 0);
    check({name, " ready"}, int'(ready), 0);
    check({name, " busy"},  int'(busy), 1);
    check({name, " x"},     int'(cx), 0);
    check({name, " y"},     int'(cy), 0);
  endtask

  initial begin
    int bad;
    int guard;

    //            ch     we    addr data   x   y  sweep base
    tbl[0]  = '{8'h07, 1'b0, 0,  8'h00, 0,  0, 0, 0};
    tbl[1]  = '{8'h08, 1'b0, 0,  8'h00, 0,  0, 0, 0};
    tbl[2]  = '{8'h68, 1'b1, 0,  8'h68, 1,  0, 0, 0};
    tbl[3]  = '{8'h0D, 1'b0, 0,  8'h00, 0,  0, 0, 0};
    tbl[4]  = '{8'h78, 1'b1, 0,  8'h78, 1,  0, 0, 0};
    tbl[5]  = '{8'h7F, 1'b0, 0,  8'h00, 1,  0, 0, 0};
    tbl[6]  = '{8'h20, 1'b1, 1,  8'h20, 2,  0, 0, 0};
    tbl[7]  = '{8'h7E, 1'b1, 2,  8'h7E, 3,  0, 0, 0};
    tbl[8]  = '{8'h08, 1'b1, 2,  8'h00, 2,  0, 0, 0};
    tbl[9]  = '{8'h0A, 1'b0, 0,  8'h00, 0,  1, 1, 76};
    tbl[10] = '{8'h08, 1'b1, 75, 8'h00, 75, 0, 0, 0};
    tbl[11] = '{8'h5A, 1'b1, 75, 8'h5A, 0,  1, 1, 76};
    tbl[12] = '{8'h1F, 1'b0, 0,  8'h00, 0,  1, 0, 0};
    tbl[13] = '{8'h0C, 1'b0, 0,  8'h00, 0,  0, 2, 0};

    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("power-up clear", 0, N);
    check("power-up x", int'(cx), 0);
    check("power-up y", int'(cy), 0);

    for (int k = 0; k < 14; k++) begin
      send(tbl[k].ch);
      check($sformatf("v%0d we", k), int'(we), int'(tbl[k].we));
      if (tbl[k].we) begin
        check($sformatf("v%0d addr", k), int'(addr), tbl[k].addr);
        check($sformatf("v%0d data", k), int'(data), int'(tbl[k].data));
      end
      check($sformatf("v%0d x", k), int'(cx), tbl[k].x);
      check($sformatf("v%0d y", k), int'(cy), tbl[k].y);
      if (tbl[k].sweep != 0) begin
        check_sweep($sformatf("v%0d sweep", k), tbl[k].base, (tbl[k].sweep == 1) ? W : N);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d single strobe", k), int'(we), 0);
      end
    end

    // Back-to-back 'A','B' with valid held for two cycles
    ch = 8'h41;
    valid = 1'b1;
    @(posedge clk);
    #1 ch = 8'h42;
    @(negedge clk);
    check("AB first we", int'(we), 1);
    check("AB first addr", int'(addr), 0);
    check("AB first data", int'(data), 8'h41);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("AB second we", int'(we), 1);
    check("AB second addr", int'(addr), 1);
    check("AB second data", int'(data), 8'h42);
    check("AB x", int'(cx), 2);
    check("AB y", int'(cy), 0);
    @(negedge clk);
    check("AB idle we", int'(we), 0);

    // Full row of printable bytes streamed from (0,0)
    send(8'h0D);
    bad = 0;
    valid = 1'b1;
    for (int i = 0; i < W; i++) begin
      ch = 8'(33 + i);
      @(posedge clk);
      @(negedge clk);
      if (!(we === 1'b1 && int'(addr) == i && data === 8'(33 + i))) bad++;
    end
    valid = 1'b0;
    check("row stream writes bad", bad, 0);
    check("row stream ready drop", int'(ready), 0);
    check("row stream y", int'(cy), 1);
    check_sweep("row wrap clear", 76, W);
    check("row wrap x", int'(cx), 0);
    check("row wrap y", int'(cy), 1);

    // Walk down to the last row, then LF wraps to row 0
    for (int j = 0; j < 42; j++) send(8'h0A);
    check("walk y", int'(cy), 43);
    for (int j = 0; j < 5; j++) send(8'h61);
    check("pre-LF x", int'(cx), 5);
    check("pre-LF y", int'(cy), 43);
    send(8'h0A);
    check("bottom LF we", int'(we), 0);
    check("bottom LF x", int'(cx), 0);
    check("bottom LF y", int'(cy), 0);
    ch = 8'h51;
    valid = 1'b1;
    check_sweep("bottom wrap clear", 0, W);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("held byte we", int'(we), 1);
    check("held byte addr", int'(addr), 0);
    check("held byte data", int'(data), 8'h51);
    check("held byte x", int'(cx), 1);

    // Reset pulse in the middle of a full-screen clear
    send(8'h0C);
    guard = 0;
    while (!(we === 1'b1 && int'(addr) == 1000) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach addr 1000", int'(addr), 1000);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid-sweep reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("restart clear", 0, N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/terminal_write_ctrl.md
Name: terminal_write_ctrl

Overview:
- Sequences all writes into the character_sprite terminal grid BRAM: accepts a byte stream over a valid/ready handshake and maintains the cursor.
- Interprets the printable and control codes, and generates the grid write port signals (tg_write_en/tg_addr/tg_input).
- Performs hardware clears: whole screen, and a single row when the cursor enters it.
- Replaces the ad-hoc button/cursor logic in top_level; debounced buttons or a UART feed its input.

Parameters:
SCREEN_WIDTH, 76, characters per row (W)
SCREEN_HEIGHT, 44, rows (H)
ADDR_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), grid address width (derived)

Ports:
clk_in  input  1  system clock (clk_pixel in top_level)
rst_in  input  1  asynchronous, active-low reset
char_in  input  8  input byte
char_valid_in  input  1  char_in valid
char_ready_out  output  1  block accepts char_in this cycle
tg_write_en_out  output  1  grid write strobe, one write per asserted cycle
tg_addr_out  output  ADDR_W  grid address = row*W + col
tg_data_out  output  8  grid write data
cursor_x_out  output  $clog2(W)  cursor column
cursor_y_out  output  $clog2(H)  cursor row
busy_out  output  1  clear sweep in progress

Behaviour:
- Reset, while rst_in=0 and asynchronously: cursor=(0,0), tg_write_en_out=0, tg_addr_out=0, tg_data_out=0, char_ready_out=0, busy_out=1. State=CLEAR_ALL with sweep pointer 0.
- States:
  - IDLE: char_ready_out=1, busy_out=0.
  - CLEAR_ROW and CLEAR_ALL: char_ready_out=0, busy_out=1.
- Transfer occurs when char_valid_in && char_ready_out on a rising edge. All grid outputs are registered: the write appears the cycle after acceptance. tg_write_en_out is high for exactly one cycle per write.
- Printable byte (0x20..0x7E):
  - Write char to (x,y) and advance x.
  - If x==W-1: x=0, y=(y==H-1)?0:y+1, then go to CLEAR_ROW for the new row.
  - Otherwise stay in IDLE. Back-to-back printable bytes sustain 1 write/cycle.
- LF (0x0A): x=0, y advances with wrap as above, then CLEAR_ROW. No character write.
- CR (0x0D): x=0. No write.
- BS (0x08):
  - At (0,0): consumed, no write, no move.
  - Otherwise move back: x-1, or (W-1, y-1) if x==0. Write 0x00 at the new position.
- FF (0x0C): go to CLEAR_ALL and set cursor=(0,0).
- Any other byte: consumed and ignored.
- CLEAR_ROW: W consecutive cycles of writes, data 0x00, addr y*W .. y*W+W-1 ascending. The first sweep write is the cycle after the transition edge, immediately following any pending char write. Return to IDLE after the last write.
- CLEAR_ALL: W*H consecutive writes, data 0x00, addr 0 .. W*H-1. Return to IDLE after the last write.
- Address arithmetic: y*W computed so the result fits ADDR_W. Sweep counters saturate at their last value and never exceed W*H-1.
- Cursor outputs update on the acceptance edge. During CLEAR_ROW they show the new row with x=0.
- char_valid_in/char_in held while ready=0 must be accepted unchanged on the first ready cycle; no bytes are dropped.
- rst_in asserted mid-sweep aborts the sweep immediately and restarts CLEAR_ALL from 0 after release.

Test Plan:
- Release reset, W=76, H=44 -> 3344 consecutive writes, addr 0..3343, data 0; then char_ready_out=1, busy_out=0, cursor (0,0).
- Stream 'A','B' with valid held 2 cycles -> writes (addr 0, 0x41) then (addr 1, 0x42) on consecutive cycles; cursor (2,0).
- 76 printable bytes from (0,0) -> last write at addr 75; ready drops; 76 zero writes at addr 76..151; cursor (0,1); ready returns.
- BS at (0,1) -> single write (addr 75, 0x00), cursor (75,0). BS at (0,0) -> no write, cursor unchanged.
- Cursor at (5,43), LF -> cursor (0,0), zero writes addr 0..75; a byte held valid during the sweep is written to addr 0 right after it.
- Pulse rst_in low during the FF sweep at addr 1000 -> outputs reset; after release the sweep restarts at addr 0 and completes 3344 writes.
